// File: rtl/bist_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// bist_pkg -- controller state encoding, default polynomials and a clog2 helper
// Rev 1.0 -- initial release
// ============================================================================
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  localparam logic [15:0] c_DEFAULT_POLY   = 16'hB400;
  localparam logic [15:0] c_DEFAULT_SEED   = 16'h0001;
  localparam logic [15:0] c_DEFAULT_GOLDEN = 16'h0000;

  // Never returns less than 1 so counters always have at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_scan_ctrl_lfsr_galois.sv
`default_nettype none
// ============================================================================
// lfsr_galois -- right-shifting Galois LFSR with parallel-XOR input (LFSR or MISR)
// Rev 1.0 -- initial release
// ============================================================================
module lfsr_galois #(
  parameter int           W     = 16,
  parameter int           OUT_W = 16,
  parameter logic [W-1:0] POLY  = 16'hB400,
  parameter logic [W-1:0] SEED  = 16'h0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [W-1:0]     i_par,
  output logic [OUT_W-1:0] o_state
);

  logic [W-1:0] r_state;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = (r_state >> 1) ^ (r_state[0] ? POLY : '0) ^ i_par;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  // Only the low bits leave the block; the pattern LFSR feeds just N_CHAINS taps.
  assign o_state = r_state[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/bist_scan_ctrl.sv
`default_nettype none
// ============================================================================
// bist_scan_ctrl -- logic-BIST controller: LFSR stimulus, shift/capture, MISR
// Rev 1.0 -- initial release
// ============================================================================
module bist_scan_ctrl
  import bist_pkg::*;
#(
  parameter int                N_CHAINS   = 1,
  parameter int                CHAIN_LEN  = 32,
  parameter int                N_PATTERNS = 1000,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = c_DEFAULT_POLY,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = c_DEFAULT_SEED,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = c_DEFAULT_POLY,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = c_DEFAULT_GOLDEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_bist_start,
  input  logic                i_bist_abort,
  input  logic [N_CHAINS-1:0] i_scan_out,
  output logic [N_CHAINS-1:0] o_scan_in,
  output logic                o_scan_en,
  output logic                o_test_mode,
  output logic                o_busy,
  output logic                o_bist_done,
  output logic                o_bist_pass,
  output logic [MISR_W-1:0]   o_signature
);

  localparam int c_BIT_W = clog2(CHAIN_LEN);
  localparam int c_PAT_W = clog2(N_PATTERNS + 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(CHAIN_LEN - 1);
  localparam logic [c_PAT_W-1:0] c_PAT_LAST = c_PAT_W'(N_PATTERNS - 1);

  bist_state_e r_state;
  bist_state_e w_state_nxt;

  logic               r_start_q;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [c_PAT_W-1:0] r_pat_cnt;

  logic w_go;
  logic w_busy;
  logic w_bit_last;
  logic w_pat_last;
  logic w_run_start;
  logic w_lfsr_adv;
  logic w_misr_adv;
  logic w_bit_inc;
  logic w_bit_clr;
  logic w_pat_inc;

  logic [N_CHAINS-1:0] w_lfsr_low;
  logic [MISR_W-1:0]   w_misr;
  logic [MISR_W-1:0]   w_misr_par;

  assign w_go       = i_bist_start & ~r_start_q;
  assign w_busy     = (r_state == ST_SHIFT) || (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);
  assign w_bit_last = (r_bit_cnt == c_BIT_LAST);
  assign w_pat_last = (r_pat_cnt == c_PAT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_start = 1'b0;
    w_lfsr_adv  = 1'b0;
    w_misr_adv  = 1'b0;
    w_bit_inc   = 1'b0;
    w_bit_clr   = 1'b0;
    w_pat_inc   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_go) begin
          w_state_nxt = ST_SHIFT;
          w_run_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_lfsr_adv = 1'b1;
        // Pattern 0 unloads whatever the chains held before the run.
        w_misr_adv = (r_pat_cnt != '0);
        if (w_bit_last) begin
          w_bit_clr   = 1'b1;
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_bit_inc = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (w_pat_last) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_pat_inc   = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        w_misr_adv = 1'b1;
        if (w_bit_last) begin
          w_bit_clr   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_bit_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Abort freezes the datapath and leaves the partial signature visible.
    if (i_bist_abort && w_busy) begin
      w_state_nxt = ST_IDLE;
      w_lfsr_adv  = 1'b0;
      w_misr_adv  = 1'b0;
      w_bit_inc   = 1'b0;
      w_bit_clr   = 1'b1;
      w_pat_inc   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_bit_cnt <= '0;
      r_pat_cnt <= '0;
    end else begin
      r_start_q <= i_bist_start;
      if (w_run_start || w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
      end
      if (w_run_start) begin
        r_pat_cnt <= '0;
      end else if (w_pat_inc) begin
        r_pat_cnt <= r_pat_cnt + c_PAT_W'(1);
      end
    end
  end

  always_comb begin
    w_misr_par                 = '0;
    w_misr_par[N_CHAINS-1:0]   = i_scan_out;
  end

  lfsr_galois #(
    .W     (LFSR_W),
    .OUT_W (N_CHAINS),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_pattern_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_run_start),
    .i_en    (w_lfsr_adv),
    .i_par   ({LFSR_W{1'b0}}),
    .o_state (w_lfsr_low)
  );

  lfsr_galois #(
    .W     (MISR_W),
    .OUT_W (MISR_W),
    .POLY  (MISR_POLY),
    .SEED  ({MISR_W{1'b0}})
  ) u_misr (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_run_start),
    .i_en    (w_misr_adv),
    .i_par   (w_misr_par),
    .o_state (w_misr)
  );

  always_comb begin
    o_scan_in   = (r_state == ST_SHIFT) ? w_lfsr_low : '0;
    o_scan_en   = (r_state == ST_SHIFT) || (r_state == ST_FLUSH);
    o_test_mode = w_busy;
    o_busy      = w_busy;
    o_bist_done = (r_state == ST_DONE);
    o_bist_pass = (r_state == ST_DONE) && (w_misr == GOLDEN_SIG);
    o_signature = w_misr;
  end

endmodule
`default_nettype wire
